// File: rtl/sea_iter_core_pkg.sv
// Shared types, S-box table and word-level helpers for the SEA iterative core.
// Helpers work on a wide container vector; B/NB select the live portion.
package sea_iter_core_pkg;

  localparam int HW_MAX = 192;
  typedef logic [HW_MAX-1:0] hw_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  // Index 0 is the rightmost entry: {0,5,6,7,4,3,1,2}.
  localparam logic [7:0][2:0] SBOX = {3'd2, 3'd1, 3'd3, 3'd4, 3'd7, 3'd6, 3'd5, 3'd0};

  // Round constant: round index zero-extended into word 0.
  function automatic hw_t rcon(input hw_t i, input int b);
    hw_t m;
    m = (hw_t'(1) << b) - hw_t'(1);
    return i & m;
  endfunction

  function automatic hw_t wadd(input hw_t x, input hw_t k, input int b, input int nb);
    hw_t  s;
    logic c;
    s = '0;
    for (int j = 0; j < nb; j++) begin
      c = 1'b0;
      for (int t = 0; t < b; t++) begin
        s[j*b+t] = x[j*b+t] ^ k[j*b+t] ^ c;
        c = (x[j*b+t] & k[j*b+t]) | (c & (x[j*b+t] ^ k[j*b+t]));
      end
    end
    return s;
  endfunction

  // Bitsliced 3-bit S-box across each word triple; word 3t carries the LSB.
  function automatic hw_t sbox_sl(input hw_t x, input int b, input int nb);
    hw_t        y;
    logic [2:0] idx;
    logic [2:0] o;
    y = '0;
    for (int t = 0; t < nb / 3; t++) begin
      for (int q = 0; q < b; q++) begin
        idx = {x[(3*t+2)*b+q], x[(3*t+1)*b+q], x[3*t*b+q]};
        o   = SBOX[idx];
        y[3*t*b+q]     = o[0];
        y[(3*t+1)*b+q] = o[1];
        y[(3*t+2)*b+q] = o[2];
      end
    end
    return y;
  endfunction

  function automatic hw_t rmix(input hw_t x, input int b, input int nb);
    hw_t y;
    y = '0;
    for (int t = 0; t < nb / 3; t++) begin
      for (int q = 0; q < b; q++) begin
        y[3*t*b+q]     = x[3*t*b + ((q + 1) % b)];
        y[(3*t+1)*b+q] = x[(3*t+1)*b + q];
        y[(3*t+2)*b+q] = x[(3*t+2)*b + ((q + b - 1) % b)];
      end
    end
    return y;
  endfunction

  function automatic hw_t wrot(input hw_t x, input int b, input int nb);
    hw_t y;
    y = '0;
    for (int j = 0; j < nb; j++)
      for (int q = 0; q < b; q++)
        y[((j + 1) % nb)*b + q] = x[j*b+q];
    return y;
  endfunction

  function automatic hw_t wrot_inv(input hw_t x, input int b, input int nb);
    hw_t y;
    y = '0;
    for (int j = 0; j < nb; j++)
      for (int q = 0; q < b; q++)
        y[j*b+q] = x[((j + 1) % nb)*b + q];
    return y;
  endfunction

  function automatic hw_t f_fn(input hw_t x, input hw_t k, input int b, input int nb);
    return rmix(sbox_sl(wadd(x, k, b, nb), b, nb), b, nb);
  endfunction

endpackage

// File: rtl/sea_round.sv
// One combinational SEA Feistel round; mode selects the encrypt or inverse step.
module sea_round
  import sea_iter_core_pkg::*;
#(
  parameter int W  = 48,
  parameter int B  = 8,
  parameter int CW = 7
) (
  input  logic [W-1:0]  l,
  input  logic [W-1:0]  r,
  input  logic [W-1:0]  k,
  input  logic [CW-1:0] i,
  input  logic          mode,
  output logic [W-1:0]  lo,
  output logic [W-1:0]  ro
);

  localparam int NB = W / B;

  logic [W-1:0] fx, fw;

  // Encrypt feeds F from the right half, decrypt from the left half.
  assign fx = mode ? l : r;
  assign fw = W'(f_fn(hw_t'(fx), hw_t'(k) ^ rcon(hw_t'(i), B), B, NB));

  always_comb begin
    if (mode) begin
      ro = l;
      lo = W'(wrot_inv(hw_t'(r ^ fw), B, NB));
    end else begin
      lo = r;
      ro = W'(wrot(hw_t'(l), B, NB)) ^ fw;
    end
  end

endmodule

// File: rtl/sea_iter_core.sv
// Iterative SEA block cipher: valid/ready in, UNROLL rounds per clock, valid/ready out.
module sea_iter_core
  import sea_iter_core_pkg::*;
#(
  parameter int W      = 48,
  parameter int B      = 8,
  parameter int NR     = 93,
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [W-1:0] li,
  input  logic [W-1:0] ri,
  input  logic [W-1:0] ki,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] lo,
  output logic [W-1:0] ro
);

  localparam int NB = W / B;
  localparam int CW = $clog2(NR + 2);

  if (W % B != 0 || NB % 3 != 0 || NB < 3 || W > HW_MAX) begin : g_bad_nb
    $error("sea_iter_core: W/B must be a nonzero multiple of 3 and W <= HW_MAX");
  end
  if (NR < 1 || NR % 2 != 1) begin : g_bad_nr
    $error("sea_iter_core: NR must be odd and >= 1");
  end
  if (UNROLL < 1 || NR % UNROLL != 0) begin : g_bad_unroll
    $error("sea_iter_core: UNROLL must divide NR");
  end

  state_e        state_q, state_d;
  logic [W-1:0]  l_q, l_d, r_q, r_d, k_q, k_d;
  logic [W-1:0]  lo_q, lo_d, ro_q, ro_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          fin;

  logic [UNROLL:0][W-1:0] lch, rch;

  assign lch[0] = l_q;
  assign rch[0] = r_q;

  for (genvar u = 0; u < UNROLL; u++) begin : g_rnd
    logic [CW-1:0] idx;
    assign idx = mode_q ? cnt_q - CW'(u) : cnt_q + CW'(u);
    sea_round #(.W(W), .B(B), .CW(CW)) u_rnd (
      .l   (lch[u]),
      .r   (rch[u]),
      .k   (k_q),
      .i   (idx),
      .mode(mode_q),
      .lo  (lch[u+1]),
      .ro  (rch[u+1])
    );
  end

  // The counter runs one step past the last round; that extra RUN cycle
  // moves the working halves into the output registers.
  assign fin = mode_q ? (cnt_q == '0) : (cnt_q == CW'(NR + 1));

  always_comb begin
    state_d  = state_q;
    l_d      = l_q;
    r_d      = r_q;
    k_d      = k_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    lo_d     = lo_q;
    ro_d     = ro_q;
    in_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = !rst;
        if (in_valid) begin
          l_d     = li;
          r_d     = ri;
          k_d     = ki;
          mode_d  = mode;
          cnt_d   = mode ? CW'(NR) : CW'(1);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (fin) begin
          lo_d    = l_q;
          ro_d    = r_q;
          state_d = ST_DONE;
        end else begin
          l_d   = lch[UNROLL];
          r_d   = rch[UNROLL];
          cnt_d = mode_q ? cnt_q - CW'(UNROLL) : cnt_q + CW'(UNROLL);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      l_q     <= '0;
      r_q     <= '0;
      k_q     <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      lo_q    <= '0;
      ro_q    <= '0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      ro_q    <= ro_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign lo        = lo_q;
  assign ro        = ro_q;

endmodule

// File: tb/tb_sea_iter_core.sv
// Directed bench for sea_iter_core: hand-computed vectors on small configs,
// round trips across UNROLL=1/3 full-size instances, back-pressure and reset abort.
module tb_sea_iter_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic        out_ready = 1'b0;
  logic [47:0] li = '0, ri = '0, ki = '0;
  logic [3:0]  iv = '0;
  logic [3:0]  ir, ov;
  logic [23:0] lo1, ro1, lo3, ro3;
  logic [47:0] lod, rod, loe, roe;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sea_iter_core #(.W(24), .B(8), .NR(1), .UNROLL(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .mode(mode),
    .li(li[23:0]), .ri(ri[23:0]), .ki(ki[23:0]), .out_valid(ov[0]),
    .out_ready(out_ready), .lo(lo1), .ro(ro1));

  sea_iter_core #(.W(24), .B(8), .NR(3), .UNROLL(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .mode(mode),
    .li(li[23:0]), .ri(ri[23:0]), .ki(ki[23:0]), .out_valid(ov[1]),
    .out_ready(out_ready), .lo(lo3), .ro(ro3));

  sea_iter_core ud (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .mode(mode),
    .li(li), .ri(ri), .ki(ki), .out_valid(ov[2]),
    .out_ready(out_ready), .lo(lod), .ro(rod));

  sea_iter_core #(.W(48), .B(8), .NR(93), .UNROLL(3)) ue (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .mode(mode),
    .li(li), .ri(ri), .ki(ki), .out_valid(ov[3]),
    .out_ready(out_ready), .lo(loe), .ro(roe));

  function automatic logic [47:0] get_lo(input int s);
    case (s)
      0:       return {24'd0, lo1};
      1:       return {24'd0, lo3};
      2:       return lod;
      default: return loe;
    endcase
  endfunction

  function automatic logic [47:0] get_ro(input int s);
    case (s)
      0:       return {24'd0, ro1};
      1:       return {24'd0, ro3};
      2:       return rod;
      default: return roe;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic send(input int s, input logic m, input logic [47:0] l, r, k);
    mode = m; li = l; ri = r; ki = k; iv[s] = 1'b1;
    chk("in_ready_idle", 48'(ir[s]), 48'd1);
    @(posedge clk); #1;
    iv[s] = 1'b0;
  endtask

  task automatic wait_out(input int s, input int elat);
    int lat;
    lat = 0;
    while (!ov[s] && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 48'(lat), 48'(elat));
  endtask

  task automatic take(input int s);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_drop", 48'(ov[s]), 48'd0);
    chk("in_ready_back", 48'(ir[s]), 48'd1);
  endtask

  task automatic xfer(input int s, input logic m, input logic [47:0] l, r, k,
                      input int elat, output logic [47:0] ol, orr);
    send(s, m, l, r, k);
    wait_out(s, elat);
    ol  = get_lo(s);
    orr = get_ro(s);
    take(s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [47:0] ol, orr, cl, cr, hl, hr;
  logic [47:0] pv_l [3];
  logic [47:0] pv_r [3];
  logic [47:0] pv_k [3];
  logic        seen;

  initial begin
    pv_l[0] = 48'h0123456789AB; pv_r[0] = 48'hCDEF01234567; pv_k[0] = 48'h001122334455;
    pv_l[1] = 48'hFFFFFFFFFFFF; pv_r[1] = 48'h000000000000; pv_k[1] = 48'hFFFFFFFFFFFF;
    pv_l[2] = 48'hA5A55A5AC3C3; pv_r[2] = 48'h3C3C96966969; pv_k[2] = 48'h0F1E2D3C4B5A;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("in_ready_in_rst", 48'(ir), 48'd0);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 48'(ov), 48'd0);
    chk("rst_lo", lod, 48'd0);
    chk("rst_ro", rod, 48'd0);
    chk("in_ready_after_rst", 48'(ir), 48'hF);
    @(posedge clk); #1;

    // NR=1, 24-bit: hand-computed vectors
    xfer(0, 1'b0, 48'h0, 48'h0, 48'h0, 2, ol, orr);
    chk("nr1_enc0_lo", ol, 48'h000000);
    chk("nr1_enc0_ro", orr, 48'h020080);
    xfer(0, 1'b1, 48'h0, 48'h020080, 48'h0, 2, ol, orr);
    chk("nr1_dec0_lo", ol, 48'h0);
    chk("nr1_dec0_ro", orr, 48'h0);
    xfer(0, 1'b0, 48'h0, 48'h0, 48'h000001, 2, ol, orr);
    chk("nr1_keycancel_ro", orr, 48'h0);
    xfer(0, 1'b0, 48'h000001, 48'h0, 48'h0, 2, ol, orr);
    chk("nr1_wrot_lo", ol, 48'h0);
    chk("nr1_wrot_ro", orr, 48'h020180);
    xfer(0, 1'b0, 48'h0, 48'h0000FF, 48'h0, 2, ol, orr);
    chk("nr1_carry_lo", ol, 48'h0000FF);
    chk("nr1_carry_ro", orr, 48'h0);

    // NR=3, UNROLL=3, 24-bit
    xfer(1, 1'b0, 48'h0, 48'h0, 48'h0, 2, ol, orr);
    chk("nr3_enc_lo", ol, 48'h010241);
    chk("nr3_enc_ro", orr, 48'h8E8220);
    xfer(1, 1'b1, 48'h010241, 48'h8E8220, 48'h0, 2, ol, orr);
    chk("nr3_dec_lo", ol, 48'h0);
    chk("nr3_dec_ro", orr, 48'h0);

    // Full size: encrypt on one unroll factor, decrypt on the other
    for (int v = 0; v < 3; v++) begin
      xfer(2, 1'b0, pv_l[v], pv_r[v], pv_k[v], 94, cl, cr);
      xfer(3, 1'b1, cl, cr, pv_k[v], 32, ol, orr);
      chk("rt_u1u3_lo", ol, pv_l[v]);
      chk("rt_u1u3_ro", orr, pv_r[v]);
      xfer(3, 1'b0, pv_l[v], pv_r[v], pv_k[v], 32, cl, cr);
      xfer(2, 1'b1, cl, cr, pv_k[v], 94, ol, orr);
      chk("rt_u3u1_lo", ol, pv_l[v]);
      chk("rt_u3u1_ro", orr, pv_r[v]);
    end

    // Back-pressure in DONE with a competing in_valid
    send(2, 1'b0, pv_l[0], pv_r[0], pv_k[0]);
    wait_out(2, 94);
    hl = lod; hr = rod;
    li = pv_l[1]; ri = pv_r[1]; ki = pv_k[1]; iv[2] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 48'(ov[2]), 48'd1);
      chk("bp_in_ready", 48'(ir[2]), 48'd0);
      chk("bp_lo_stable", lod, hl);
      chk("bp_ro_stable", rod, hr);
    end
    iv[2] = 1'b0;
    take(2);
    xfer(3, 1'b1, hl, hr, pv_k[0], 32, ol, orr);
    chk("bp_rt_lo", ol, pv_l[0]);
    chk("bp_rt_ro", orr, pv_r[0]);

    // Reset in the middle of a block
    send(2, 1'b0, pv_l[2], pv_r[2], pv_k[2]);
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_out_valid", 48'(ov[2]), 48'd0);
    chk("abort_lo", lod, 48'd0);
    chk("abort_ro", rod, 48'd0);
    chk("abort_in_ready", 48'(ir[2]), 48'd1);
    seen = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (ov[2]) seen = 1'b1;
    end
    chk("abort_no_stale", 48'(seen), 48'd0);
    xfer(2, 1'b0, pv_l[1], pv_r[1], pv_k[1], 94, cl, cr);
    xfer(3, 1'b1, cl, cr, pv_k[1], 32, ol, orr);
    chk("post_rst_rt_lo", ol, pv_l[1]);
    chk("post_rst_rt_ro", orr, pv_r[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
